// File: rtl/mtr_spd_sequencer.sv
// -----------------------------------------------------------------------------
// mtr_spd_sequencer
//   Feeds signed 12-bit speed commands to the motor driver. A target pair is
//   taken over a valid/ready handshake. Each channel then moves toward its
//   target by at most STEP once every RAMP_DIV clocks. When a step would
//   reverse the sign of a channel, that channel is held at zero for one tick so
//   the H-bridge gets dead time. estop zeroes both channels at once.
//
// Optional feature: define MTR_DEADBAND_EN to latch any target with
//   |t| < DEADBAND as 0.
//
// Ports
//   clk        clock
//   rst_n      asynchronous active-low reset
//   cmd_vld    target pair valid
//   cmd_rdy    ready to accept a target pair (IDLE and no estop)
//   cmd_lft    signed left target speed
//   cmd_rght   signed right target speed
//   estop      emergency stop, level, synchronous to clk
//   lft_spd    registered signed left speed to the motor driver
//   rght_spd   registered signed right speed to the motor driver
//   ramp_busy  high while ramping
//   at_target  both outputs equal the latched targets
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | outputs at target, waiting for a command
// RAMP  | stepping the outputs toward the targets on every ramp tick
// ESTOP | outputs forced to zero; leaves once estop is sampled low
// -----------------------------------------------------------------------------
module mtr_spd_sequencer #(
   parameter int RAMP_DIV = 1024,
   parameter int STEP     = 16,
   parameter int DEADBAND = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               cmd_vld,
   output logic               cmd_rdy,
   input  logic signed [11:0] cmd_lft,
   input  logic signed [11:0] cmd_rght,
   input  logic               estop,
   output logic signed [11:0] lft_spd,
   output logic signed [11:0] rght_spd,
   output logic               ramp_busy,
   output logic               at_target
);

`ifdef MTR_DEADBAND_EN
   localparam bit DB_EN = 1'b1;
`else
   localparam bit DB_EN = 1'b0;
`endif

   localparam int                 CW     = $clog2(RAMP_DIV);
   localparam logic [CW-1:0]      CNT_TC = CW'(RAMP_DIV - 1);
   localparam logic signed [12:0] STEP13 = 13'(STEP);
   localparam logic signed [12:0] DB13   = 13'(DEADBAND);

   typedef enum logic [1:0] {IDLE, RAMP, ESTOP} state_t;

   state_t             state, state_nxt;
   logic [CW-1:0]      cnt, cnt_nxt;
   logic signed [11:0] tgt_l, tgt_r, tgt_l_nxt, tgt_r_nxt;
   logic signed [11:0] lft_nxt, rght_nxt;
   logic signed [11:0] db_l, db_r;

   function automatic logic signed [11:0] deadband(input logic signed [11:0] t);
      logic signed [12:0] t13, mag;
      t13 = {t[11], t};
      mag = t13[12] ? -t13 : t13;
      if (DB_EN && (mag < DB13))
         return '0;
      return t;
   endfunction

   // Arithmetic is done in 13 bits so that -2048 -> 2047 cannot overflow.
   // The stepped value never goes past tgt, so it always fits back into 12 bits.
   function automatic logic signed [11:0] step_ch(input logic signed [11:0] cur,
                                                  input logic signed [11:0] tgt);
      logic signed [12:0] c, d, mag, nxt;
      c   = {cur[11], cur};
      d   = {tgt[11], tgt} - c;
      mag = d[12] ? -d : d;
      if (mag > STEP13)
         mag = STEP13;
      nxt = d[12] ? (c - mag) : (c + mag);
      // The step would cross zero: park at zero for one tick.
      if ((!c[12] && (c != 13'sd0) && nxt[12]) || (c[12] && !nxt[12] && (nxt != 13'sd0)))
         return '0;
      return nxt[11:0];
   endfunction

   assign db_l      = deadband(cmd_lft);
   assign db_r      = deadband(cmd_rght);
   assign cmd_rdy   = (state == IDLE) && !estop;
   assign ramp_busy = (state == RAMP);
   assign at_target = (lft_spd == tgt_l) && (rght_spd == tgt_r);

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      tgt_l_nxt = tgt_l;
      tgt_r_nxt = tgt_r;
      lft_nxt   = lft_spd;
      rght_nxt  = rght_spd;
      if (estop) begin
         state_nxt = ESTOP;
         cnt_nxt   = '0;
         tgt_l_nxt = '0;
         tgt_r_nxt = '0;
         lft_nxt   = '0;
         rght_nxt  = '0;
      end else begin
         case (state)
            IDLE: begin
               if (cmd_vld) begin
                  tgt_l_nxt = db_l;
                  tgt_r_nxt = db_r;
                  cnt_nxt   = '0;
                  if ((db_l != lft_spd) || (db_r != rght_spd))
                     state_nxt = RAMP;
               end
            end
            RAMP: begin
               if (cnt == CNT_TC) begin
                  cnt_nxt  = '0;
                  lft_nxt  = step_ch(lft_spd, tgt_l);
                  rght_nxt = step_ch(rght_spd, tgt_r);
                  if ((lft_nxt == tgt_l) && (rght_nxt == tgt_r))
                     state_nxt = IDLE;
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
            ESTOP:   state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         tgt_l    <= '0;
         tgt_r    <= '0;
         lft_spd  <= '0;
         rght_spd <= '0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         tgt_l    <= tgt_l_nxt;
         tgt_r    <= tgt_r_nxt;
         lft_spd  <= lft_nxt;
         rght_spd <= rght_nxt;
      end
   end

endmodule
